// File: rtl/ast_mask_gen2.sv
// ast_mask_gen2: segment-test corner detector over a circular pixel mask, 5-stage valid/ready pipeline.
// Define AST_CORNER_CNT_EN to add the per-frame corner counter output corner_cnt.
module ast_mask_gen2 #(
  parameter int C    = 16,
  parameter int W    = 8,
  parameter int NW   = 5,
  parameter int CNTW = 20
) (
  input  logic            c,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [C*W-1:0]  dm,
  input  logic [W-1:0]    dc,
  input  logic [W-1:0]    t,
  input  logic [NW-1:0]   n,
  input  logic            mode,
  input  logic            sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            q,
  output logic            dark,
  output logic [W-1:0]    score
`ifdef AST_CORNER_CNT_EN
  ,
  output logic [CNTW-1:0] corner_cnt
`endif
);
  localparam int L  = $clog2(C);
  localparam int RW = L + 2;
  localparam int SW = W + L;

  logic                w_adv, w_acc, r_rdy;
  logic [4:0]          r_v;
  logic [C*W-1:0]      r0_dm;
  logic [W-1:0]        r0_dc, r0_t, r1_t;
  logic [NW-1:0]       r0_n, r1_n, r2_n;
  logic                r0_m, r1_m, r2_m, r3_m;
  logic [W+1:0]        w_d [C];
  logic [C-1:0][W-1:0] w_abs, r1_abs;
  logic [C-1:0]        w_fd, w_fl, r1_fd, r1_fl;
  logic [RW-1:0]       w_rd, w_rl, r2_rd, r2_rl, w_ne;
  logic [SW-1:0]       w_sa, w_sd, w_sl, r2_sa, r2_sd, r2_sl, r3_sa, r3_sx;
  logic                w_qd, w_ql, r3_q, r3_dk, r4_q, r4_dk;
  logic [W-1:0]        w_sc, r4_sc;

  // Scanning the flags twice lets a run wrap from pixel C-1 to 0; all-ones clamps to C.
  function automatic logic [RW-1:0] run_len(input logic [C-1:0] f);
    logic [RW-1:0] cur, mx;
    cur = '0;
    mx  = '0;
    for (int j = 0; j < 2 * C; j++) begin
      cur = f[j % C] ? cur + 1'b1 : '0;
      mx  = cur > mx ? cur : mx;
    end
    return mx > RW'(C) ? RW'(C) : mx;
  endfunction

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv & r_rdy;
  assign w_acc    = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < C; i++) begin
      w_d[i]   = {2'b00, r0_dm[i*W +: W]} - {2'b00, r0_dc};
      w_abs[i] = w_d[i][W+1] ? W'(-w_d[i]) : w_d[i][W-1:0];
      w_fd[i]  = w_d[i][W+1] && (w_abs[i] > r0_t);
      w_fl[i]  = !w_d[i][W+1] && (w_abs[i] > r0_t);
    end
  end

  assign w_rd = run_len(r1_fd);
  assign w_rl = run_len(r1_fl);

  always_comb begin
    w_sa = '0;
    w_sd = '0;
    w_sl = '0;
    for (int i = 0; i < C; i++) begin
      w_sa = w_sa + SW'(r1_abs[i]);
      w_sd = w_sd + (r1_fd[i] ? SW'(r1_abs[i] - r1_t) : '0);
      w_sl = w_sl + (r1_fl[i] ? SW'(r1_abs[i] - r1_t) : '0);
    end
  end

  assign w_ne = r2_n > NW'(C) ? RW'(C) : RW'(r2_n);
  assign w_qd = (w_ne != '0) && (r2_rd >= w_ne);
  assign w_ql = (w_ne != '0) && (r2_rl >= w_ne);
  assign w_sc = !r3_q ? '0 : r3_m ? (|r3_sx[SW-1:W] ? '1 : r3_sx[W-1:0]) : W'(r3_sa >> L);

  always_ff @(posedge c)
    if (w_adv) begin
      r0_dm  <= dm;
      r0_dc  <= dc;
      r0_t   <= t;
      r0_n   <= n;
      r0_m   <= mode;
      r1_abs <= w_abs;
      r1_fd  <= w_fd;
      r1_fl  <= w_fl;
      r1_t   <= r0_t;
      r1_n   <= r0_n;
      r1_m   <= r0_m;
      r2_rd  <= w_rd;
      r2_rl  <= w_rl;
      r2_sa  <= w_sa;
      r2_sd  <= w_sd;
      r2_sl  <= w_sl;
      r2_n   <= r1_n;
      r2_m   <= r1_m;
      r3_q   <= w_qd | w_ql;
      r3_dk  <= w_qd;
      r3_sa  <= r2_sa;
      r3_sx  <= w_qd ? r2_sd : r2_sl;
      r3_m   <= r2_m;
      r4_q   <= r3_q;
      r4_dk  <= r3_dk;
      r4_sc  <= w_sc;
    end

  always_ff @(posedge c or negedge rst_n)
    if (!rst_n) begin
      r_rdy     <= 1'b0;
      r_v       <= '0;
      out_valid <= 1'b0;
      q         <= 1'b0;
      dark      <= 1'b0;
      score     <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_adv) begin
        r_v       <= {r_v[3:0], w_acc};
        out_valid <= r_v[4];
        q         <= r_v[4] & r4_q;
        dark      <= r_v[4] & r4_dk;
        score     <= r_v[4] ? r4_sc : '0;
      end
    end

`ifdef AST_CORNER_CNT_EN
  logic [5:0] r_sof;

  always_ff @(posedge c)
    if (w_adv) r_sof <= {r_sof[4:0], sof};

  always_ff @(posedge c or negedge rst_n)
    if (!rst_n) corner_cnt <= '0;
    else if (out_valid && out_ready)
      corner_cnt <= r_sof[5] ? CNTW'(q) : (q && !(&corner_cnt)) ? corner_cnt + 1'b1 : corner_cnt;
`else
  logic [CNTW-1:0] w_unused_cnt;
  assign w_unused_cnt = {CNTW{sof}};
`endif
endmodule

// File: tb/tb_ast_mask_gen2.sv
// tb_ast_mask_gen2: randomized scoreboard bench for ast_mask_gen2 against a segment-test reference model.
module tb_ast_mask_gen2;
  localparam int C = 16, W = 8, NW = 5, CNTW = 20;

  logic c = 0, rst_n = 1, in_valid = 0, in_ready, mode = 0, sof = 0;
  logic out_valid, out_ready = 1, q, dark;
  logic [C*W-1:0] dm = '0;
  logic [W-1:0] dc = '0, t = '0, score;
  logic [NW-1:0] n = '0;
`ifdef AST_CORNER_CNT_EN
  logic [CNTW-1:0] corner_cnt;
`endif

  typedef struct {
    logic [C*W-1:0] dm;
    logic [W-1:0] dc, t;
    logic [NW-1:0] n;
    logic mode, sof;
  } stim_t;
  typedef struct {
    logic q, dark, sof, lat;
    logic [W-1:0] score;
    int acc;
  } exp_t;

  stim_t sq[$];
  exp_t eq[$];
  exp_t e;
  int checks = 0, errs = 0, cyc = 0, m_cnt = 0;
  bit chk_cnt = 0, held = 0, pres = 0;

  ast_mask_gen2 #(.C(C), .W(W), .NW(NW), .CNTW(CNTW)) dut (
    .c(c), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dm(dm), .dc(dc), .t(t), .n(n), .mode(mode), .sof(sof),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .dark(dark), .score(score)
`ifdef AST_CORNER_CNT_EN
    , .corner_cnt(corner_cnt)
`endif
  );

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit arc(input logic [C-1:0] f, input int ne);
    bit ok;
    if (ne == 0) return 0;
    for (int s = 0; s < C; s++) begin
      ok = 1;
      for (int k = 0; k < ne; k++) if (!f[(s + k) % C]) ok = 0;
      if (ok) return 1;
    end
    return 0;
  endfunction

  function automatic exp_t model(input stim_t s, input bit lat, input int acc);
    exp_t r;
    int d, a, sa, sd, sl, ne, x;
    logic [C-1:0] fd, fl;
    bit qd, ql;
    sa = 0; sd = 0; sl = 0;
    for (int i = 0; i < C; i++) begin
      d = int'(s.dm[i*W +: W]) - int'(s.dc);
      a = d < 0 ? -d : d;
      fd[i] = (-d > int'(s.t));
      fl[i] = (d > int'(s.t));
      sa += a;
      if (fd[i]) sd += a - int'(s.t);
      if (fl[i]) sl += a - int'(s.t);
    end
    ne = int'(s.n) > C ? C : int'(s.n);
    qd = arc(fd, ne);
    ql = arc(fl, ne);
    x = qd ? sd : sl;
    r.q = qd | ql;
    r.dark = qd;
    r.score = !r.q ? 8'd0 : s.mode ? W'(x > 255 ? 255 : x) : W'(sa / C);
    r.sof = s.sof;
    r.lat = lat;
    r.acc = acc;
    return r;
  endfunction

  function automatic stim_t mk(input int px, input int dcv, input int tv, input int nv, input bit md, input bit sf);
    stim_t s;
    for (int i = 0; i < C; i++) s.dm[i*W +: W] = W'(px);
    s.dc = W'(dcv);
    s.t = W'(tv);
    s.n = NW'(nv);
    s.mode = md;
    s.sof = sf;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    int tv, dcv, pol, st, len, v;
    dcv = $urandom_range(255);
    tv = $urandom_range(40);
    s.dc = W'(dcv);
    s.t = W'(tv);
    s.n = ($urandom_range(3) == 0) ? NW'($urandom_range(31)) : NW'($urandom_range(16, 6));
    s.mode = 1'($urandom_range(1));
    s.sof = ($urandom_range(9) == 0);
    pol = $urandom_range(2);
    st = $urandom_range(C - 1);
    len = $urandom_range(C, 4);
    for (int i = 0; i < C; i++) begin
      v = dcv + int'($urandom_range(2 * tv)) - tv;
      if (pol != 0 && ((i - st + C) % C) < len)
        v = pol == 1 ? dcv - tv - 1 - int'($urandom_range(60)) : dcv + tv + 1 + int'($urandom_range(60));
      if ($urandom_range(15) == 0) v = $urandom_range(255);
      v = v < 0 ? 0 : v > 255 ? 255 : v;
      s.dm[i*W +: W] = W'(v);
    end
    return s;
  endfunction

  task automatic drive(input int rdy_pct, input int gap_pct, input bit lat, input bit sched);
    bit accepted = 0;
    int j = 0;
    while (sq.size() > 0 || in_valid) begin
      @(negedge c);
      if (accepted) begin
        in_valid = 0;
        accepted = 0;
      end
      out_ready = sched ? !(j >= 3 && j <= 6) : ($urandom_range(99) < rdy_pct);
      if (!in_valid && sq.size() > 0 && $urandom_range(99) >= gap_pct) begin
        dm = sq[0].dm; dc = sq[0].dc; t = sq[0].t; n = sq[0].n;
        mode = sq[0].mode; sof = sq[0].sof;
        in_valid = 1;
      end
      #1;
      if (in_valid && in_ready) begin
        eq.push_back(model(sq[0], lat, cyc + 1));
        void'(sq.pop_front());
        accepted = 1;
      end
      j++;
    end
  endtask

  task automatic drain();
    int w = 0;
    @(negedge c);
    out_ready = 1;
    while (eq.size() > 0 && w < 200) begin
      @(negedge c);
      w++;
    end
    if (eq.size() > 0) begin
      checks++;
      errs++;
      $display("FAIL drain: %0d results outstanding, required 0", eq.size());
    end
  endtask

  initial begin
    forever begin
      @(negedge c);
      #2;
      if (!rst_n) begin
        held = 0;
        pres = 0;
      end else begin
`ifdef AST_CORNER_CNT_EN
        if (chk_cnt) chk("corner_cnt", int'(corner_cnt), m_cnt);
`endif
        chk_cnt = 0;
        if (held) chk("hold_valid", out_valid, 1);
        held = 0;
        if (out_valid) begin
          if (eq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_output: q=%0d score=%0h with no result outstanding", q, score);
          end else begin
            if (!pres) begin
              pres = 1;
              if (eq[0].lat) chk("latency", cyc - eq[0].acc, 5);
            end
            if (out_ready) begin
              e = eq.pop_front();
              chk("q", q, e.q);
              chk("dark", dark, e.dark);
              chk("score", score, e.score);
              m_cnt = e.sof ? int'(e.q) : m_cnt + int'(e.q);
              chk_cnt = 1;
              pres = 0;
            end else begin
              chk("held_q", q, eq[0].q);
              chk("held_score", score, eq[0].score);
              held = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    stim_t s;
    #1 rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_score", score, 0);
    chk("rst_in_ready", in_ready, 0);
`ifdef AST_CORNER_CNT_EN
    chk("rst_corner_cnt", int'(corner_cnt), 0);
`endif
    repeat (3) @(negedge c);
    rst_n = 1;
    #1 chk("ready_before_edge", in_ready, 0);
    @(posedge c);
    #1 chk("ready_after_release", in_ready, 1);

    sq.push_back(mk(8'h80, 8'h80, 8'h10, 9, 0, 1));
    s = mk(8'h80, 8'h80, 8'h10, 10, 1, 0);
    for (int i = 0; i < 10; i++) s.dm[i*W +: W] = 8'h60;
    repeat (3) sq.push_back(s);
    s.sof = 1;
    sq.push_back(s);
    s = mk(8'h80, 8'h80, 8'h10, 9, 1, 0);
    for (int i = 12; i < 21; i++) s.dm[(i % C)*W +: W] = 8'hA0;
    sq.push_back(s);
    s.n = 10;
    sq.push_back(s);
    sq.push_back(mk(8'h70, 8'h80, 8'h10, 1, 1, 0));
    sq.push_back(mk(8'h00, 8'hFF, 8'h00, 12, 0, 0));
    sq.push_back(mk(8'h00, 8'hFF, 8'h00, 0, 0, 0));
    sq.push_back(mk(8'h00, 8'hFF, 8'h00, 31, 0, 0));
    sq.push_back(mk(8'h00, 8'hFF, 8'h00, 16, 1, 0));
    s = mk(8'hB0, 8'h80, 8'h08, 8, 1, 0);
    for (int i = 0; i < 8; i++) s.dm[i*W +: W] = 8'h40;
    sq.push_back(s);
    drive(100, 0, 1, 0);
    drain();

    repeat (8) sq.push_back(rnd());
    drive(0, 0, 0, 1);
    drain();

    repeat (300) sq.push_back(rnd());
    drive(75, 30, 0, 0);
    drain();

    repeat (4) sq.push_back(rnd());
    drive(0, 0, 0, 0);
    repeat (4) @(negedge c);
    #3 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_q", q, 0);
    chk("midrst_dark", dark, 0);
    chk("midrst_score", score, 0);
    chk("midrst_in_ready", in_ready, 0);
`ifdef AST_CORNER_CNT_EN
    chk("midrst_corner_cnt", int'(corner_cnt), 0);
`endif
    eq.delete();
    m_cnt = 0;
    chk_cnt = 0;
    repeat (2) @(negedge c);
    rst_n = 1;
    out_ready = 1;
    #1 chk("midrst_ready_before_edge", in_ready, 0);
    @(posedge c);
    #1 chk("midrst_ready_after_release", in_ready, 1);
    repeat (10) @(negedge c);
    chk("midrst_no_output", out_valid, 0);

    s = mk(8'h80, 8'h80, 8'h10, 10, 1, 1);
    for (int i = 0; i < 10; i++) s.dm[i*W +: W] = 8'h60;
    sq.push_back(s);
    repeat (3) sq.push_back(rnd());
    drive(100, 0, 1, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
